// File: rtl/bcd_pkg.sv
// Shared types and widths for the BCD entry and conversion blocks.
// Imported by bcd_digit_entry, bcd_digit_chk and bcd_bin.
package bcd_pkg;

  typedef enum logic {COLLECT, HOLD} entry_state_t;

  localparam int BCD_MAX_DIGIT = 9;

  function automatic int BCD_W(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/bcd_digit_chk.sv
// Combinational legality check for one BCD digit (0..9).
// Shared by the entry front end and bcd_bin input checking.
module bcd_digit_chk
  import bcd_pkg::*;
(
  input  logic [3:0] dig,
  output logic       legal
);

  assign legal = (dig <= 4'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_digit_entry.sv
// Collects decimal digits MSD-first into a packed BCD word and
// presents it on a valid/ready output when enter is issued.
module bcd_digit_entry
  import bcd_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 dig,
  input  logic                       dig_valid,
  output logic                       dig_ready,
  input  logic                       enter,
  input  logic                       clr,
  output logic [BCD_W(NDIG)-1:0]     bcd,
  output logic                       bcd_valid,
  input  logic                       bcd_ready,
  output logic [$clog2(NDIG+1)-1:0]  ndig,
  output logic                       err
);

  localparam int W  = BCD_W(NDIG);
  localparam int NW = $clog2(NDIG + 1);

  entry_state_t  state_q, state_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          dig_legal;

  bcd_digit_chk u_chk (
    .dig   (dig),
    .legal (dig_legal)
  );

  assign dig_ready = (state_q == COLLECT);
  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign ndig      = ndig_q;
  assign err       = err_q;

  // Next state: digit shift-in first, then commit; clr overrides all.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    if (clr) begin
      state_d = COLLECT;
      bcd_d   = '0;
      ndig_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (dig_valid) begin
            if (!dig_legal || ndig_q == NW'(NDIG)) begin
              err_d = 1'b1;
            end else begin
              bcd_d  = (bcd_q << 4) | W'(dig);
              ndig_d = ndig_q + NW'(1);
            end
          end
          if (enter) begin
            if (ndig_d == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (bcd_ready) begin
            state_d = COLLECT;
            bcd_d   = '0;
            ndig_d  = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      bcd_q   <= '0;
      ndig_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/bcd_digit_entry.md
# bcd_digit_entry

Sequential front end for `bcd_bin`: collects single decimal digits one per handshake, such as from a keypad scanner, and assembles them MSD-first into a packed BCD word. On an `enter` command it presents the word on a valid/ready output. `bcd_bin` reads `bcd` directly to produce the binary value. The block also checks the digits, rejects malformed or excess input, and holds output under backpressure.

## Interface
- `NDIG`, default 2: digit capacity. Output width is `4*NDIG`. The default of 2 matches the 8-bit `bcd_bin` input.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `dig`, in, 4: incoming digit, 0–9 legal.
- `dig_valid`, in, 1: `dig` is offered this cycle.
- `dig_ready`, out, 1: block can accept a digit. High in COLLECT, low in HOLD.
- `enter`, in, 1: single-cycle command to commit the collected digits.
- `clr`, in, 1: synchronous clear. Highest priority after `rst`.
- `bcd`, out, `4*NDIG`: packed BCD. Most significant digit is in the top nibble; unused leading nibbles are 0.
- `bcd_valid`, out, 1: `bcd` holds a committed value.
- `bcd_ready`, in, 1: downstream accepts `bcd`.
- `ndig`, out, `$clog2(NDIG+1)`: number of digits currently collected.
- `err`, out, 1: one-cycle pulse on any rejected input.

## Operation
- States:
  - COLLECT: accumulating digits.
  - HOLD: committed word presented, waiting for `bcd_ready`.
- Digit accept occurs in a cycle where `dig_valid && dig_ready`:
  - `dig > 9`: digit discarded, `err` pulses.
  - `ndig == NDIG`: digit discarded, `err` pulses. The oldest digit is never shifted out.
  - Otherwise: `bcd <= {bcd[4*NDIG-5:0], dig}` and `ndig` increments.
- `enter` in COLLECT:
  - If the post-accept `ndig` is 0: `err` pulses and the block stays in COLLECT.
  - Otherwise: go to HOLD and set `bcd_valid` to 1.
- `enter` and an accepted digit in the same cycle: the digit is included first, then the commit is applied. A legal digit entered into an empty register therefore commits successfully.
- `enter` in HOLD: ignored, no `err`.
- A digit offered in HOLD is not accepted because `dig_ready` is 0. The upstream must hold it.
- HOLD exits when `bcd_ready` is sampled high. The next state is COLLECT with `bcd = 0`, `ndig = 0`, and `bcd_valid = 0`.
- `clr` in any state, any cycle:
  - Next state is COLLECT with `bcd = 0`, `ndig = 0`, and `bcd_valid = 0`.
  - Any digit, `enter`, or `err` in the same cycle is suppressed.
- In COLLECT, `bcd` shows the live partial value (for display) with `bcd_valid` at 0. Consumers qualify on `bcd_valid`.
- Width rules:
  - `ndig` saturates at `NDIG`.
  - No arithmetic is performed on `bcd`; the only shift is 4 bits left per digit.

## Timing
- Reset values, applied asynchronously:
  - state COLLECT
  - `bcd = 0`, `ndig = 0`, `bcd_valid = 0`, `err = 0`
  - `dig_ready = 1`, since it is derived combinationally from the state.
- Digit latency: a digit accepted at edge N is visible in `bcd` and `ndig` after edge N.
- Commit latency: `enter` sampled at edge N gives `bcd_valid = 1` after edge N.
- Output transfer happens at the edge where `bcd_valid && bcd_ready`. `bcd_valid` is 0 after that edge. There is no same-cycle re-entry, so there is a minimum one-cycle bubble.
- `bcd` and `bcd_valid` are stable for as long as HOLD persists.
- `err` is registered: it is high for exactly the one cycle after the offending edge.
- `rst` asserted mid-collection or in HOLD discards all state immediately, with no output transfer.

## Structure
- Shared package `bcd_pkg`:
  - `typedef enum logic {COLLECT, HOLD} entry_state_t`
  - `localparam int BCD_MAX_DIGIT = 9`
  - `BCD_W(n) = 4*n` helper
  - `bcd_bin` imports the same package for its width.
- One natural sub-module, `bcd_digit_chk`: a combinational legality check on a 4-bit digit, reused later by `bcd_bin` input checking.
- Everything else is a single always_ff plus next-state logic in `bcd_digit_entry`.

## Test plan
- After reset, send digits 4 then 2, then `enter` → `bcd = 8'h42`, `bcd_valid` high the cycle after `enter`, `bcd_bin` output equals 42. `bcd_ready` high → next cycle `bcd = 0`, `dig_ready = 1`.
- Send digit 7 with `enter` in the same cycle → `bcd = 8'h07`, `ndig = 1`, `bcd_valid = 1`, no `err`.
- Send digit 4'hC, then digits 9, 9, 5 → `err` pulses for C and for 5, and `bcd = 8'h99`. `enter` with no digits collected → `err` pulse, state stays COLLECT.
- Commit 8'h35 with `bcd_ready` low for 5 cycles while `dig_valid` is held with 1 → `bcd` stays 8'h35, `dig_ready = 0`, digit not accepted. Raise `bcd_ready` → transfer, then digit 1 accepted → `bcd = 8'h01`.
- `clr` in HOLD, and `clr` concurrent with a digit and `enter` → COLLECT, `bcd = 0`, `ndig = 0`, no `err`, no `bcd_valid`.
- Assert `rst` asynchronously between edges with 1 digit collected and again in HOLD → all outputs return to their reset values immediately and the next transaction completes normally.
